dtcm_ctrl: RTL and testbench
============================

DTCM_CTRL -- requirements
Module: dtcm_ctrl

Interface
REQ-001 Parameter AW, 14, SRAM word-address width.
REQ-002 Parameter DW, 32, SRAM data width; only 32 is supported.
REQ-003 Parameter MW, 4, SRAM byte-write-mask width (DW/8).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  LSU request valid.
REQ-007 req_ready  output  1  controller accepts the request this cycle.
REQ-008 req_read  input  1  1 = load, 0 = store.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  LSU accepts the response.
REQ-014 rsp_rdata  output  32  load data: shifted right to bit 0, zero-extended; 0 for stores.
REQ-015 rsp_err  output  1  access error.
REQ-016 ram_we, ram_addr[AW-1:0], ram_din[DW-1:0], ram_wem[MW-1:0]  outputs  drive the DTCM SRAM port.
REQ-017 ram_dout  input  DW  SRAM read data, valid one cycle after the address is presented.

Function
REQ-018 A request is accepted when req_valid && req_ready are both high.
REQ-019 ram_addr = req_addr[AW+1:2], combinational.
REQ-020 ram_din = the store data replicated into every lane: byte x4, half x2, word x1.
REQ-021 ram_wem per size and offset: byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],1'b0}, word 4'b1111.
REQ-022 ram_we = 1 only on the accept cycle of an error-free store.
REQ-023 When ram_we = 0, ram_wem = 0.
REQ-024 On accept, the FSM registers offset, size, read flag and err.
REQ-025 FSM state IDLE: rsp_valid = 0; req_ready = 1; an accept moves the FSM to RESP.
REQ-026 FSM state RESP: rsp_valid = 1; rsp_rdata is derived from ram_dout (combinational).
REQ-027 In RESP, req_ready = rsp_ready.
REQ-028 In RESP with rsp_ready = 1: go to RESP if a new request is accepted, otherwise go to IDLE.
REQ-029 In RESP with rsp_ready = 0: capture the formatted data and err into a hold register; go to HOLD.
REQ-030 FSM state HOLD: rsp_valid = 1; rsp_rdata and rsp_err come from the hold register; req_ready = rsp_ready.
REQ-031 HOLD exits on rsp_ready = 1: to RESP if a new request is accepted the same cycle, otherwise to IDLE.
REQ-032 Latency is 1 cycle from accept to rsp_valid.
REQ-033 Throughput is 1 request per cycle when rsp_ready is held high.
REQ-034 At most one outstanding response exists.
REQ-035 rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.
REQ-036 Load formatting: byte = {24'b0, word[8*off+:8]}; half = {16'b0, word[16*off[1]+:16]}; word unchanged.
REQ-037 Store responses carry rsp_rdata = 0.

Reset
REQ-038 While rst is high: FSM = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-039 While rst is high: req_ready = 0, ram_we = 0, ram_wem = 0, and the hold register is cleared.
REQ-040 Reset asserted in RESP or HOLD drops the pending response; no response is issued after reset.

Configuration
REQ-041 Macro DTCM_CTRL_ALIGN_CHK_EN, when defined, flags as errors: size 11, half with addr[0] = 1, word with addr[1:0] != 0.
REQ-042 With DTCM_CTRL_ALIGN_CHK_EN defined, an errored request is accepted with no RAM write and gets rsp_err = 1, rsp_rdata = 0.
REQ-043 Without DTCM_CTRL_ALIGN_CHK_EN: rsp_err is tied 0; size 11 is treated as word.
REQ-044 Without DTCM_CTRL_ALIGN_CHK_EN: address bits below the access size are ignored (aligned down).

Verification
REQ-045 Store word 0xDEADBEEF @0x10 -> ram_we = 1, ram_addr = 4, ram_wem = 4'b1111; next cycle rsp_valid = 1, rsp_rdata = 0, rsp_err = 0.
REQ-046 Store byte 0xA5 @0x13 -> ram_wem = 4'b1000, ram_din = 0xA5A5A5A5. Then load word @0x10 -> rsp_rdata = 0xA5ADBEEF.
REQ-047 Load half @0x12 with rsp_ready low for 3 cycles, SRAM word 0x12345678 -> rsp_rdata = 0x00001234 held stable all 4 cycles; req_ready = 0 until the handshake.
REQ-048 Back-to-back loads @0x0, 0x4, 0x8 with rsp_ready = 1 -> req_ready stays 1; three responses on consecutive cycles, in order.
REQ-049 With DTCM_CTRL_ALIGN_CHK_EN defined, store word @0x22 -> ram_we = 0; rsp_err = 1. Without the macro -> write @ word 8, rsp_err = 0.
REQ-050 Reset asserted in the HOLD state -> next cycle rsp_valid = 0, FSM in IDLE; the first request after reset completes normally.

Source files
------------

// File: rtl/dtcm_ctrl.sv
// DTCM SRAM controller: single-port LSU bridge, one-cycle read latency, one outstanding response.
// Optional alignment/size checking is enabled by defining DTCM_CTRL_ALIGN_CHK_EN.
module dtcm_ctrl #(
    parameter int AW = 14,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_read,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t      state, state_nxt;
    logic [1:0]  off_q, size_q;
    logic        read_q, err_q;
    logic [31:0] hold_data;
    logic        hold_err;

    logic        accept, req_err;
    logic [1:0]  size_eff;
    logic [3:0]  mask;
    logic [31:0] shifted, fmt_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW+2];

    always_comb begin
`ifdef DTCM_CTRL_ALIGN_CHK_EN
        req_err  = (req_size == 2'b11)
                 | ((req_size == 2'b01) && req_addr[0])
                 | ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        size_eff = req_size;
`else
        // reserved size behaves as a word access; low address bits are simply ignored
        req_err  = 1'b0;
        size_eff = (req_size == 2'b11) ? 2'b10 : req_size;
`endif
    end

    always_comb begin
        mask    = 4'b1111;
        ram_din = req_wdata;
        case (size_eff)
            2'b00: begin
                mask    = 4'b0001 << req_addr[1:0];
                ram_din = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                mask    = 4'b0011 << {req_addr[1], 1'b0};
                ram_din = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign req_ready = rst ? 1'b0 : ((state == IDLE) ? 1'b1 : rsp_ready);
    assign accept    = req_valid && req_ready;
    assign ram_addr  = req_addr[AW+1:2];
    assign ram_we    = accept && !req_read && !req_err;
    assign ram_wem   = ram_we ? mask : '0;

    always_comb begin
        fmt_data = '0;
        shifted  = '0;
        if (read_q && !err_q) begin
            case (size_q)
                2'b00: begin
                    shifted  = ram_dout >> {off_q, 3'b000};
                    fmt_data = {24'b0, shifted[7:0]};
                end
                2'b01: begin
                    shifted  = ram_dout >> {off_q[1], 4'b0000};
                    fmt_data = {16'b0, shifted[15:0]};
                end
                default: fmt_data = ram_dout;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = fmt_data;
                rsp_err   = err_q;
                if (rsp_ready) state_nxt = accept ? RESP : IDLE;
                else           state_nxt = HOLD;
            end
            HOLD: begin
                rsp_valid = 1'b1;
                rsp_rdata = hold_data;
                rsp_err   = hold_err;
                if (rsp_ready) state_nxt = accept ? RESP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            rsp_valid = 1'b0;
            rsp_rdata = '0;
            rsp_err   = 1'b0;
        end
    end

    // SRAM output is only valid in RESP, so a stalled response is frozen here
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q     <= '0;
            size_q    <= '0;
            read_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else begin
            if (accept) begin
                off_q  <= req_addr[1:0];
                size_q <= size_eff;
                read_q <= req_read;
                err_q  <= req_err;
            end
            if (state == RESP && !rsp_ready) begin
                hold_data <= fmt_data;
                hold_err  <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Randomized self-checking bench for dtcm_ctrl against a transaction-level memory model.
// Honours DTCM_CTRL_ALIGN_CHK_EN the same way as the design.
module tb_dtcm_ctrl;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_read, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, rsp_valid, rsp_err, ram_we;
    logic [31:0] rsp_rdata, ram_din, ram_dout;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wem;

    int n_checks = 0;
    int n_fail   = 0;

    dtcm_ctrl #(.AW(14), .DW(32), .MW(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wem(ram_wem),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // SRAM behavioural model: one-cycle read latency, byte-masked writes
    logic [31:0] sram [0:63];
    always @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_wem[i]) sram[ram_addr[5:0]][8*i +: 8] <= ram_din[8*i +: 8];
        ram_dout <= sram[ram_addr[5:0]];
    end

    // Reference model state
    logic [31:0] mem [0:63];
    bit          pend;
    logic [31:0] pend_data;
    bit          pend_err;

    // Last observed outputs
    logic        o_rr, o_rv, o_re, o_we;
    logic [31:0] o_rd, o_din;
    logic [13:0] o_addr;
    logic [3:0]  o_wem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
`ifdef DTCM_CTRL_ALIGN_CHK_EN
        return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
`else
        return 0;
`endif
    endfunction

    task automatic cycle(input logic r, input logic v, input logic rd, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd, input logic rr);
        bit          exp_ready, acc, err, exp_we;
        logic [3:0]  exp_mask;
        logic [31:0] exp_din, ld;
        int unsigned w, off, sh;
        @(posedge clk); #1;
        rst = r; req_valid = v; req_read = rd; req_addr = a;
        req_size = sz; req_wdata = wd; rsp_ready = rr;
        @(negedge clk);
        o_rr = req_ready; o_rv = rsp_valid; o_rd = rsp_rdata; o_re = rsp_err;
        o_we = ram_we; o_wem = ram_wem; o_addr = ram_addr; o_din = ram_din;

        exp_ready = !r && (!pend || rr);
        check("req_ready", {31'b0, o_rr}, {31'b0, exp_ready});
        check("rsp_valid", {31'b0, o_rv}, {31'b0, !r && pend});
        check("rsp_rdata", o_rd, (!r && pend) ? pend_data : 32'h0);
        check("rsp_err",   {31'b0, o_re}, {31'b0, !r && pend && pend_err});

        w   = a / 4 % 64;
        off = a % 4;
        err = model_err(sz, a);
        acc = v && exp_ready;
        exp_we = acc && !rd && !err;
        exp_mask = 4'b0;
        for (int i = 0; i < 4; i++)
            if (sz == 0 ? (i == off) : sz == 1 ? (i / 2 == off / 2) : 1'b1)
                exp_mask = exp_mask | 4'(1 << i);
        exp_din = (sz == 0) ? (wd & 32'hFF) * 32'h01010101 :
                  (sz == 1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        check("ram_we",   {31'b0, o_we}, {31'b0, exp_we});
        check("ram_wem",  {28'b0, o_wem}, exp_we ? {28'b0, exp_mask} : 32'h0);
        check("ram_addr", {18'b0, o_addr}, (a / 4) % 16384);
        if (exp_we) check("ram_din", o_din, exp_din);

        if (r) pend = 0;
        else begin
            if (pend && rr) pend = 0;
            if (acc) begin
                if (exp_we)
                    for (int i = 0; i < 4; i++)
                        if (exp_mask[i]) mem[w][8*i +: 8] = exp_din[8*i +: 8];
                sh = (sz == 0) ? 8 * off : (sz == 1) ? 8 * (off & 2) : 0;
                ld = mem[w] >> sh;
                if (sz == 0)      ld = ld & 32'hFF;
                else if (sz == 1) ld = ld & 32'hFFFF;
                pend      = 1;
                pend_err  = err;
                pend_data = (rd && !err) ? ld : 32'h0;
            end
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, rr);
    endtask

    initial begin
        pend = 0; pend_data = 0; pend_err = 0;
        rst = 1; req_valid = 0; req_read = 0; req_addr = 0; req_size = 0; req_wdata = 0; rsp_ready = 0;

        cycle(1'b1, 1'b1, 1'b0, 32'h10, 2'b10, 32'h1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 1'b0);
        check("reset_req_ready", {31'b0, o_rr}, 32'h0);

        for (int unsigned i = 0; i < 64; i++)
            cycle(1'b0, 1'b1, 1'b0, i * 4, 2'b10, $urandom, 1'b1);
        idle(1'b1);

        // store word, then its response
        cycle(1'b0, 1'b1, 1'b0, 32'h10, 2'b10, 32'hDEADBEEF, 1'b1);
        check("sw_we", {31'b0, o_we}, 32'h1);
        check("sw_addr", {18'b0, o_addr}, 32'h4);
        check("sw_wem", {28'b0, o_wem}, 32'hF);
        idle(1'b1);
        check("sw_rsp_valid", {31'b0, o_rv}, 32'h1);
        check("sw_rsp_rdata", o_rd, 32'h0);

        // store byte into top lane, read back the merged word
        cycle(1'b0, 1'b1, 1'b0, 32'h13, 2'b00, 32'hA5, 1'b1);
        check("sb_wem", {28'b0, o_wem}, 32'h8);
        check("sb_din", o_din, 32'hA5A5A5A5);
        cycle(1'b0, 1'b1, 1'b1, 32'h10, 2'b10, 32'h0, 1'b1);
        idle(1'b1);
        check("lw_merged", o_rd, 32'hA5ADBEEF);

        // stalled half load stays stable
        cycle(1'b0, 1'b1, 1'b0, 32'h10, 2'b10, 32'h12345678, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h12, 2'b01, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 32'h0, 2'b10, 32'h0, i == 3);
            check("lh_hold_data", o_rd, 32'h00001234);
            check("lh_hold_ready", {31'b0, o_rr}, (i == 3) ? 32'h1 : 32'h0);
        end
        idle(1'b1);

        // back-to-back loads at full throughput
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, i * 4, 2'b10, 32'h0, 1'b1);
            check("b2b_ready", {31'b0, o_rr}, 32'h1);
        end
        idle(1'b1);
        idle(1'b1);

        // misaligned word store
        cycle(1'b0, 1'b1, 1'b0, 32'h22, 2'b10, 32'hCAFEF00D, 1'b1);
`ifdef DTCM_CTRL_ALIGN_CHK_EN
        check("mis_we", {31'b0, o_we}, 32'h0);
        idle(1'b1);
        check("mis_err", {31'b0, o_re}, 32'h1);
`else
        check("mis_we", {31'b0, o_we}, 32'h1);
        check("mis_addr", {18'b0, o_addr}, 32'h8);
        idle(1'b1);
        check("mis_err", {31'b0, o_re}, 32'h0);
`endif

        // reset while holding a response
        cycle(1'b0, 1'b1, 1'b1, 32'h10, 2'b10, 32'h0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 1'b0);
        idle(1'b1);
        check("post_rst_valid", {31'b0, o_rv}, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h10, 2'b10, 32'h0, 1'b1);
        idle(1'b1);
        check("post_rst_rsp", {31'b0, o_rv}, 32'h1);

        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                  $urandom_range(0, 255), 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 9) < 7));
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
